// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - 2048 board owner: orients a move, steps the left-move stage, commits, spawns, evaluates.
// Optional macro SPAWN_FOUR_EN: a spawned tile is a 4 when lfsr[7:4]==0 (otherwise always a 2).
module move_sequencer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [3:0]  WIN_VALUE = 4'd11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 move_req,
  input  logic [1:0]           move_dir,
  input  logic                 new_game,
  input  logic                 load_en,
  input  logic [3:0][3:0][3:0] load_grid,
  output logic [31:0]          count,
  output logic [3:0][3:0][3:0] stage_grid,
  input  logic [3:0][3:0][3:0] stage_grid_in,
  input  logic [31:0]          stage_points,
  output logic [3:0][3:0][3:0] grid,
  output logic [31:0]          score,
  output logic                 busy,
  output logic                 done,
  output logic                 won,
  output logic                 lost
);
  typedef logic [3:0][3:0][3:0] grid_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_COMMIT, S_SPAWN, S_EVAL, S_DONE} state_t;

  // Map the board so that the requested move becomes a LEFT move on [x][y].
  function automatic grid_t orient(input grid_t g, input logic [1:0] d);
    grid_t      r;
    logic [1:0] x, y;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      x = i[1:0];
      y = i[3:2];
      case (d)
        2'd0:    r[x][y] = g[x][y];
        2'd1:    r[x][y] = g[2'd3 - x][y];
        2'd2:    r[x][y] = g[y][x];
        default: r[x][y] = g[y][2'd3 - x];
      endcase
    end
    return r;
  endfunction

  function automatic grid_t inverse(input grid_t g, input logic [1:0] d);
    grid_t      r;
    logic [1:0] x, y;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      x = i[1:0];
      y = i[3:2];
      case (d)
        2'd0:    r[x][y] = g[x][y];
        2'd1:    r[x][y] = g[2'd3 - x][y];
        2'd2:    r[x][y] = g[y][x];
        default: r[x][y] = g[2'd3 - y][x];
      endcase
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  grid_t       grid_q, grid_d, work_q, work_d;
  logic [1:0]  dir_q, dir_d;
  logic [31:0] score_q, score_d, pts_q, pts_d;
  logic [2:0]  count_q, count_d;
  logic [3:0]  idx_q, idx_d, scan_q, scan_d;
  logic        again_q, again_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        busy_q, busy_d, done_q, done_d, won_q, won_d, lost_q, lost_d;

  logic       any_win, any_empty, any_pair, spawn_fin;
  logic [3:0] tile;

  always_comb begin
    logic [1:0] x, y;
    any_win   = 1'b0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      x = i[1:0];
      y = i[3:2];
      if (grid_q[x][y] == WIN_VALUE) any_win = 1'b1;
      if (grid_q[x][y] == 4'd0) any_empty = 1'b1;
      if (x != 2'd3 && grid_q[x][y] == grid_q[x + 2'd1][y]) any_pair = 1'b1;
      if (y != 2'd3 && grid_q[x][y] == grid_q[x][y + 2'd1]) any_pair = 1'b1;
    end
  end

  always_comb begin
`ifdef SPAWN_FOUR_EN
    tile = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
`else
    tile = 4'd1;
`endif
  end

  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    work_d    = work_q;
    dir_d     = dir_q;
    score_d   = score_q;
    pts_d     = pts_q;
    count_d   = 3'd0;
    idx_d     = idx_q;
    scan_d    = scan_q;
    again_d   = again_q;
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    done_d    = 1'b0;
    won_d     = won_q;
    lost_d    = lost_q;
    spawn_fin = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (new_game) begin
          grid_d  = '0;
          score_d = 32'd0;
          won_d   = 1'b0;
          lost_d  = 1'b0;
          idx_d   = lfsr_q[3:0];
          scan_d  = 4'd0;
          again_d = 1'b1;
          state_d = S_SPAWN;
        end else if (move_req && !(won_q || lost_q)) begin
          dir_d   = move_dir;
          state_d = S_LOAD;
        end else if (load_en) begin
          grid_d = load_grid;
        end
      end
      S_LOAD: begin
        work_d  = orient(grid_q, dir_q);
        state_d = S_STEP;
      end
      S_STEP: begin
        work_d = stage_grid_in;
        if (count_q == 3'd4) pts_d = stage_points;
        if (count_q == 3'd5) state_d = S_COMMIT;
        else count_d = count_q + 3'd1;
      end
      S_COMMIT: begin
        if (work_q != orient(grid_q, dir_q)) begin
          grid_d  = inverse(work_q, dir_q);
          score_d = score_q + pts_q;
          idx_d   = lfsr_q[3:0];
          scan_d  = 4'd0;
          again_d = 1'b0;
          state_d = S_SPAWN;
        end else begin
          state_d = S_EVAL;
        end
      end
      S_SPAWN: begin
        if (grid_q[idx_q[1:0]][idx_q[3:2]] == 4'd0) begin
          grid_d[idx_q[1:0]][idx_q[3:2]] = tile;
          spawn_fin = 1'b1;
        end else begin
          idx_d     = idx_q + 4'd1;
          scan_d    = scan_q + 4'd1;
          spawn_fin = (scan_q == 4'd15);
        end
        // new_game places two tiles; the second scan restarts from a fresh LFSR index.
        if (spawn_fin) begin
          if (again_q) begin
            again_d = 1'b0;
            idx_d   = lfsr_q[3:0];
            scan_d  = 4'd0;
          end else begin
            state_d = S_EVAL;
          end
        end
      end
      S_EVAL: begin
        won_d   = won_q | any_win;
        lost_d  = lost_q | (!any_empty && !any_pair);
        state_d = S_DONE;
      end
      default: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grid_q  <= '0;
      work_q  <= '0;
      dir_q   <= 2'd0;
      score_q <= 32'd0;
      pts_q   <= 32'd0;
      count_q <= 3'd0;
      idx_q   <= 4'd0;
      scan_q  <= 4'd0;
      again_q <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      won_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      work_q  <= work_d;
      dir_q   <= dir_d;
      score_q <= score_d;
      pts_q   <= pts_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      scan_q  <= scan_d;
      again_q <= again_d;
      lfsr_q  <= lfsr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      won_q   <= won_d;
      lost_q  <= lost_d;
    end
  end

  assign count      = {29'd0, count_q};
  assign stage_grid = work_q;
  assign grid       = grid_q;
  assign score      = score_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign won        = won_q;
  assign lost       = lost_q;
endmodule
